// File: rtl/riscv_pkg.sv
// Shared opcodes, FSM state encoding, ALU codes and datapath select codes for the multicycle RV32I controller.
// Pure definitions: no latency and no flow control of its own.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI,
    ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // RES_LINK returns the already-incremented PC as the rd value of jumps
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_LINK   = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic branch_cond(input logic [2:0] funct3, input logic zero,
                                       input logic lt, input logic ltu);
    logic taken;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps alu_op/funct3/funct7b5 to ALUControl; purely combinational, zero latency.
// No flow control: output follows inputs in the same cycle.
module mc_alu_dec
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        // immediates never subtract: funct7b5 there is part of the immediate
        case (funct3)
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLT;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with retired-instruction counter; 3-5 cycles per instruction.
// Memory states hold mem_req until mem_ready; mem_ready elsewhere is ignored.
module mc_controller
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter bit          TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t     state, next;
  logic [1:0] alu_op;
  logic       retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next    = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_R:              next = EXER;
          OP_I:              next = EXEI;
          OP_BRANCH:         next = BRANCH;
          OP_JAL:            next = JAL;
          OP_JALR:           next = JALR;
          OP_LUI, OP_AUIPC:  next = UPPER;
          default:           next = TRAP_EN ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        next    = op[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_DATA;
        next      = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next = FETCH;
      end
      EXER, EXEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = (state == EXEI) ? SRCB_IMM : SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        next    = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        next     = FETCH;
      end
      BRANCH: begin
        // target was latched in ALUOut during DECODE; the ALU now compares rs1/rs2
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        if (TRAP_EN && funct3[2:1] == 2'b01) begin
          next = TRAP;
        end else begin
          PCWrite = branch_cond(funct3, Zero, Lt, Ltu);
          next    = FETCH;
        end
      end
      JAL, JALR: begin
        ALUSrcA   = (state == JAL) ? SRCA_OLDPC : SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = (state == JAL) ? IMM_J : IMM_I;
        ResultSrc = RES_LINK;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        next      = FETCH;
      end
      UPPER: begin
        ALUSrcA   = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_U;
        ResultSrc = RES_ALURES;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: next = FETCH;
    endcase
    // FETCH's enables depend on mem_ready, so they must be masked while reset is held
    if (!reset) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  mc_alu_dec u_alu_dec (
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_op     (alu_op),
    .ALUControl (ALUControl)
  );

  assign retire = (next == FETCH) && (state != FETCH) && (state != DECODE) && (state != TRAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: three instances (default, TRAP_EN=0, CNT_W=4) share one stimulus stream.
module tb_mc_controller;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
  logic       mem_ready = 1'b1;

  logic [2:0] mem_req, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, illegal;
  logic [1:0] ResultSrc [3];
  logic [1:0] ALUSrcA [3];
  logic [1:0] ALUSrcB [3];
  logic [2:0] ImmSrc [3];
  logic [2:0] ALUControl [3];
  logic [31:0] ret_a, ret_b;
  logic [3:0]  ret_c;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(32), .TRAP_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready), .mem_req(mem_req[0]),
    .PCWrite(PCWrite[0]), .IRWrite(IRWrite[0]), .AdrSrc(AdrSrc[0]), .MemWrite(MemWrite[0]),
    .RegWrite(RegWrite[0]), .ResultSrc(ResultSrc[0]), .ALUSrcA(ALUSrcA[0]), .ALUSrcB(ALUSrcB[0]),
    .ImmSrc(ImmSrc[0]), .ALUControl(ALUControl[0]), .illegal(illegal[0]), .retired(ret_a));

  mc_controller #(.CNT_W(32), .TRAP_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready), .mem_req(mem_req[1]),
    .PCWrite(PCWrite[1]), .IRWrite(IRWrite[1]), .AdrSrc(AdrSrc[1]), .MemWrite(MemWrite[1]),
    .RegWrite(RegWrite[1]), .ResultSrc(ResultSrc[1]), .ALUSrcA(ALUSrcA[1]), .ALUSrcB(ALUSrcB[1]),
    .ImmSrc(ImmSrc[1]), .ALUControl(ALUControl[1]), .illegal(illegal[1]), .retired(ret_b));

  mc_controller #(.CNT_W(4), .TRAP_EN(1'b1)) u_c (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready), .mem_req(mem_req[2]),
    .PCWrite(PCWrite[2]), .IRWrite(IRWrite[2]), .AdrSrc(AdrSrc[2]), .MemWrite(MemWrite[2]),
    .RegWrite(RegWrite[2]), .ResultSrc(ResultSrc[2]), .ALUSrcA(ALUSrcA[2]), .ALUSrcB(ALUSrcB[2]),
    .ImmSrc(ImmSrc[2]), .ALUControl(ALUControl[2]), .illegal(illegal[2]), .retired(ret_c));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH with memory always ready, then checks the FSM is back in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int ncyc, input string tag);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    repeat (ncyc) step();
    exp_ret++;
    check({tag, "_state"}, 32'(u_a.state), 32'(FETCH));
    check({tag, "_retired"}, ret_a, 32'(exp_ret));
  endtask

  // Walks an ALU instruction into its execute state and checks the decoded ALU op.
  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [2:0] exp_alu, input string tag);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    step(); step();
    check({tag, "_alu"}, 32'(ALUControl[0]), 32'(exp_alu));
    step(); step();
    exp_ret++;
    check({tag, "_retired"}, ret_a, 32'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #11;
    check("rst_state", 32'(u_a.state), 32'(FETCH));
    check("rst_retired", ret_a, 32'd0);
    check("rst_irwrite", 32'(IRWrite[0]), 32'd0);
    check("rst_pcwrite", 32'(PCWrite[0]), 32'd0);
    check("rst_regwrite", 32'(RegWrite[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("fetch_memreq", 32'(mem_req[0]), 32'd1);
    check("fetch_irwrite", 32'(IRWrite[0]), 32'd1);
    check("fetch_adrsrc", 32'(AdrSrc[0]), 32'd0);

    // add x3,x1,x2
    step();
    check("add_decode", 32'(u_a.state), 32'(DECODE));
    check("add_dec_srca", 32'(ALUSrcA[0]), 32'(2'b01));
    check("add_dec_regwrite", 32'(RegWrite[0]), 32'd0);
    step();
    check("add_exer", 32'(u_a.state), 32'(EXER));
    check("add_exer_alu", 32'(ALUControl[0]), 32'(3'b000));
    check("add_exer_regwrite", 32'(RegWrite[0]), 32'd0);
    step();
    check("add_aluwb", 32'(u_a.state), 32'(ALUWB));
    check("add_aluwb_regwrite", 32'(RegWrite[0]), 32'd1);
    check("add_aluwb_resultsrc", 32'(ResultSrc[0]), 32'(2'b00));
    step();
    exp_ret = 1;
    check("add_fetch", 32'(u_a.state), 32'(FETCH));
    check("add_retired", ret_a, 32'd1);
    check("add_fetch_regwrite", 32'(RegWrite[0]), 32'd0);

    // 4-bit counter wraps 15 -> 0 on the 16th instruction
    for (int i = 2; i <= 16; i++) begin
      run_instr(OP_R, 3'b000, 1'b0, 4, "loop_add");
      check("wrap_cnt", 32'(ret_c), 32'(exp_ret % 16));
      if (i == 15) check("wrap_at15", 32'(ret_c), 32'd15);
    end
    check("wrap_to0", 32'(ret_c), 32'd0);
    check("wide_no_wrap", ret_a, 32'd16);

    alu_instr(OP_R, 3'b000, 1'b1, 3'b001, "sub");
    alu_instr(OP_I, 3'b000, 1'b1, 3'b000, "addi_f7");
    alu_instr(OP_I, 3'b101, 1'b1, 3'b111, "srai_srl");
    alu_instr(OP_R, 3'b111, 1'b0, 3'b010, "and");
    alu_instr(OP_R, 3'b100, 1'b0, 3'b100, "xor");

    // lw with three wait cycles in MEMRD
    op = OP_LOAD; funct3 = 3'b010;
    step(); step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_memrd", 32'(u_a.state), 32'(MEMRD));
      check("lw_memreq", 32'(mem_req[0]), 32'd1);
      check("lw_adrsrc", 32'(AdrSrc[0]), 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_memrd4", 32'(u_a.state), 32'(MEMRD));
    check("lw_memreq4", 32'(mem_req[0]), 32'd1);
    step();
    check("lw_memwb", 32'(u_a.state), 32'(MEMWB));
    check("lw_memwb_regwrite", 32'(RegWrite[0]), 32'd1);
    check("lw_memwb_resultsrc", 32'(ResultSrc[0]), 32'(2'b01));
    check("lw_memwb_memreq", 32'(mem_req[0]), 32'd0);
    step();
    exp_ret++;
    check("lw_retired", ret_a, 32'(exp_ret));

    run_instr(OP_STORE, 3'b010, 1'b0, 4, "sw");

    // bne: PCWrite follows !Zero combinationally
    op = OP_BRANCH; funct3 = 3'b001;
    step(); step();
    check("bne_state", 32'(u_a.state), 32'(BRANCH));
    Zero = 1'b1; #1;
    check("bne_z1_pcwrite", 32'(PCWrite[0]), 32'd0);
    Zero = 1'b0; #1;
    check("bne_z0_pcwrite", 32'(PCWrite[0]), 32'd1);
    check("bne_alu", 32'(ALUControl[0]), 32'(3'b001));
    step();
    exp_ret++;
    check("bne_retired", ret_a, 32'(exp_ret));

    // blt on Lt, bgeu on !Ltu
    funct3 = 3'b100;
    step(); step();
    Lt = 1'b1; #1;
    check("blt_lt1", 32'(PCWrite[0]), 32'd1);
    Lt = 1'b0; #1;
    check("blt_lt0", 32'(PCWrite[0]), 32'd0);
    step();
    exp_ret++;
    funct3 = 3'b111; Ltu = 1'b1;
    step(); step();
    check("bgeu_ltu1", 32'(PCWrite[0]), 32'd0);
    Ltu = 1'b0;
    step();
    exp_ret++;
    check("bgeu_retired", ret_a, 32'(exp_ret));

    op = OP_JAL;
    step(); step();
    check("jal_state", 32'(u_a.state), 32'(JAL));
    check("jal_pcwrite", 32'(PCWrite[0]), 32'd1);
    check("jal_regwrite", 32'(RegWrite[0]), 32'd1);
    check("jal_immsrc", 32'(ImmSrc[0]), 32'(3'b011));
    step();
    exp_ret++;

    op = OP_LUI;
    step(); step();
    check("lui_state", 32'(u_a.state), 32'(UPPER));
    check("lui_regwrite", 32'(RegWrite[0]), 32'd1);
    check("lui_srca", 32'(ALUSrcA[0]), 32'(2'b11));
    step();
    exp_ret++;
    run_instr(OP_AUIPC, 3'b000, 1'b0, 3, "auipc");

    // reserved branch funct3: traps with TRAP_EN=1, never taken with TRAP_EN=0
    op = OP_BRANCH; funct3 = 3'b010; Zero = 1'b1;
    step(); step();
    check("b010_pcwrite_notrap", 32'(PCWrite[1]), 32'd0);
    step();
    check("b010_trap", 32'(u_a.state), 32'(TRAP));
    check("b010_notrap_fetch", 32'(u_b.state), 32'(FETCH));
    Zero = 1'b0;

    reset = 1'b0; #2; reset = 1'b1;
    op = OP_STORE; funct3 = 3'b010;
    step(); step(); step();
    mem_ready = 1'b0; #1;
    check("sw_memwr", 32'(u_a.state), 32'(MEMWR));
    check("sw_memwrite", 32'(MemWrite[0]), 32'd1);
    check("sw_ret_before", ret_a, 32'd0);
    reset = 1'b0; #1;
    check("rst_memwrite", 32'(MemWrite[0]), 32'd0);
    check("rst_mid_state", 32'(u_a.state), 32'(FETCH));
    check("rst_mid_memreq", 32'(mem_req[0]), 32'd0);
    #2 reset = 1'b1; #1;
    check("rel_state", 32'(u_a.state), 32'(FETCH));
    check("rel_retired", ret_a, 32'd0);
    check("rel_memreq", 32'(mem_req[0]), 32'd1);
    step();
    check("fetch_hold", 32'(u_a.state), 32'(FETCH));

    // illegal opcode
    op = 7'b0000000; mem_ready = 1'b1;
    step();
    check("ill_decode", 32'(u_a.state), 32'(DECODE));
    step();
    check("ill_trapen0_fetch", 32'(u_b.state), 32'(FETCH));
    check("ill_trapen0_illegal", 32'(illegal[1]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("trap_illegal", 32'(illegal[0]), 32'd1);
      check("trap_memreq", 32'(mem_req[0]), 32'd0);
      check("trap_state", 32'(u_a.state), 32'(TRAP));
      step();
    end
    check("trap_retired", ret_a, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
